// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-index width, datapath width and the
// writeback arbiter state encoding.
package cpu_pkg;

   localparam int REG_IDX_W = 5;
   localparam int XLEN      = 32;

   typedef enum logic [0:0] {
      NORMAL = 1'b0,
      FORCE1 = 1'b1
   } arb_state_e;

   // $0 is hardwired zero, so only non-zero indices really write or bypass
   function automatic logic writes_reg(input logic [REG_IDX_W-1:0] idx);
      return (idx != {REG_IDX_W{1'b0}});
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bus: two request channels, register-file write port,
// and the bypass read-address/forward-data pairs.
interface regfile_wb_arbiter_if;
   import cpu_pkg::*;

   logic                 req0_valid;
   logic [REG_IDX_W-1:0] req0_addr;
   logic [XLEN-1:0]      req0_data;
   logic                 req0_ready;
   logic                 req1_valid;
   logic [REG_IDX_W-1:0] req1_addr;
   logic [XLEN-1:0]      req1_data;
   logic                 req1_ready;
   logic                 wb_en;
   logic [REG_IDX_W-1:0] wb_addr;
   logic [XLEN-1:0]      wb_data;
   logic [REG_IDX_W-1:0] rd_addr_0;
   logic [REG_IDX_W-1:0] rd_addr_1;
   logic                 fwd_hit_0;
   logic [XLEN-1:0]      fwd_data_0;
   logic                 fwd_hit_1;
   logic [XLEN-1:0]      fwd_data_1;

   modport master (
      output req0_valid, req0_addr, req0_data,
      output req1_valid, req1_addr, req1_data,
      output rd_addr_0, rd_addr_1,
      input  req0_ready, req1_ready,
      input  wb_en, wb_addr, wb_data,
      input  fwd_hit_0, fwd_data_0, fwd_hit_1, fwd_data_1
   );

   modport slave (
      input  req0_valid, req0_addr, req0_data,
      input  req1_valid, req1_addr, req1_data,
      input  rd_addr_0, rd_addr_1,
      output req0_ready, req1_ready,
      output wb_en, wb_addr, wb_data,
      output fwd_hit_0, fwd_data_0, fwd_hit_1, fwd_data_1
   );

endinterface

// File: rtl/wb_stage_reg.sv
// Single-entry writeback stage: holds the accepted write for one cycle and
// compares it against the two read ports for bypass.
module wb_stage_reg
   import cpu_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_en,
   input  logic [REG_IDX_W-1:0] load_addr,
   input  logic [XLEN-1:0]      load_data,
   input  logic [REG_IDX_W-1:0] rd_addr_0,
   input  logic [REG_IDX_W-1:0] rd_addr_1,
   output logic                 wb_en,
   output logic [REG_IDX_W-1:0] wb_addr,
   output logic [XLEN-1:0]      wb_data,
   output logic                 fwd_hit_0,
   output logic [XLEN-1:0]      fwd_data_0,
   output logic                 fwd_hit_1,
   output logic [XLEN-1:0]      fwd_data_1
);

   logic                 wb_en_r;
   logic [REG_IDX_W-1:0] wb_addr_r;
   logic [XLEN-1:0]      wb_data_r;

   // Stage register; a write to $0 is accepted upstream but never enabled here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_en_r   <= 1'b0;
         wb_addr_r <= {REG_IDX_W{1'b0}};
         wb_data_r <= {XLEN{1'b0}};
      end else begin
         wb_en_r <= load_en && writes_reg(load_addr);
         if (load_en) begin
            wb_addr_r <= load_addr;
            wb_data_r <= load_data;
         end
      end
   end

   // Bypass compare against both read ports
   always_comb begin
      fwd_hit_0  = 1'b0;
      fwd_data_0 = {XLEN{1'b0}};
      fwd_hit_1  = 1'b0;
      fwd_data_1 = {XLEN{1'b0}};
      if (wb_en_r && (wb_addr_r == rd_addr_0) && writes_reg(rd_addr_0)) begin
         fwd_hit_0  = 1'b1;
         fwd_data_0 = wb_data_r;
      end else begin
         fwd_hit_0  = 1'b0;
         fwd_data_0 = {XLEN{1'b0}};
      end
      if (wb_en_r && (wb_addr_r == rd_addr_1) && writes_reg(rd_addr_1)) begin
         fwd_hit_1  = 1'b1;
         fwd_data_1 = wb_data_r;
      end else begin
         fwd_hit_1  = 1'b0;
         fwd_data_1 = {XLEN{1'b0}};
      end
   end

   assign wb_en   = wb_en_r;
   assign wb_addr = wb_addr_r;
   assign wb_data = wb_data_r;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester register-file writeback arbiter: req0 has priority until req1
// has lost STARVE_LIMIT consecutive cycles, then req1 is forced through once.
module regfile_wb_arbiter
   import cpu_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   regfile_wb_arbiter_if.slave  bus
);

   localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   arb_state_e           state_r;
   arb_state_e           state_next_s;
   logic [CNT_W-1:0]     cnt_r;
   logic [CNT_W-1:0]     cnt_next_s;
   logic                 gnt0_s;
   logic                 gnt1_s;
   logic                 load_en_s;
   logic [REG_IDX_W-1:0] load_addr_s;
   logic [XLEN-1:0]      load_data_s;

   // Grant decision: depends only on valids, state and reset, never on data
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if (!rst_n) begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end else begin
         case (state_r)
            NORMAL: begin
               gnt0_s = bus.req0_valid;
               gnt1_s = bus.req1_valid && !bus.req0_valid;
            end
            FORCE1: begin
               gnt1_s = bus.req1_valid;
               gnt0_s = bus.req0_valid && !bus.req1_valid;
            end
            default: begin
               gnt0_s = 1'b0;
               gnt1_s = 1'b0;
            end
         endcase
      end
   end

   assign bus.req0_ready = gnt0_s;
   assign bus.req1_ready = gnt1_s;

   // Starve counter and FSM next state; FORCE1 also exits if req1 withdraws
   always_comb begin
      cnt_next_s   = cnt_r;
      state_next_s = state_r;
      if (gnt1_s || !bus.req1_valid) begin
         cnt_next_s = {CNT_W{1'b0}};
      end else if (cnt_r < CNT_MAX) begin
         cnt_next_s = cnt_r + CNT_W'(1);
      end else begin
         cnt_next_s = cnt_r;
      end
      case (state_r)
         NORMAL: begin
            if (cnt_next_s == CNT_MAX) begin
               state_next_s = FORCE1;
            end else begin
               state_next_s = NORMAL;
            end
         end
         FORCE1: begin
            if (gnt1_s || !bus.req1_valid) begin
               state_next_s = NORMAL;
            end else begin
               state_next_s = FORCE1;
            end
         end
         default: state_next_s = NORMAL;
      endcase
   end

   // FSM state and starve counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= NORMAL;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_next_s;
         cnt_r   <= cnt_next_s;
      end
   end

   // Winner's address/data into the stage
   always_comb begin
      load_en_s   = gnt0_s || gnt1_s;
      load_addr_s = bus.req0_addr;
      load_data_s = bus.req0_data;
      if (gnt1_s) begin
         load_addr_s = bus.req1_addr;
         load_data_s = bus.req1_data;
      end else begin
         load_addr_s = bus.req0_addr;
         load_data_s = bus.req0_data;
      end
   end

   wb_stage_reg u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_en    (load_en_s),
      .load_addr  (load_addr_s),
      .load_data  (load_data_s),
      .rd_addr_0  (bus.rd_addr_0),
      .rd_addr_1  (bus.rd_addr_1),
      .wb_en      (bus.wb_en),
      .wb_addr    (bus.wb_addr),
      .wb_data    (bus.wb_data),
      .fwd_hit_0  (bus.fwd_hit_0),
      .fwd_data_0 (bus.fwd_data_0),
      .fwd_hit_1  (bus.fwd_hit_1),
      .fwd_data_1 (bus.fwd_data_1)
   );

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive cycles req1 may lose to req0 before a forced req1 grant.
REQ-002 SHALL have port clk input 1: single clock; all state on posedge.
REQ-003 SHALL have port rst_n input 1: reset, asynchronous and active-low.
REQ-004 SHALL have ports req0_valid input 1, req0_addr input 5, req0_data input 32: pipeline writeback request.
REQ-005 SHALL have port req0_ready output 1: req0 accepted this cycle.
REQ-006 SHALL have ports req1_valid input 1, req1_addr input 5, req1_data input 32: multi-cycle/load unit writeback request.
REQ-007 SHALL have port req1_ready output 1: req1 accepted this cycle.
REQ-008 SHALL have ports wb_en output 1, wb_addr output 5, wb_data output 32: registered register-file write port.
REQ-009 SHALL have ports rd_addr_0 input 5, rd_addr_1 input 5: register-file read addresses, for bypass compare.
REQ-010 SHALL have ports fwd_hit_0 output 1, fwd_data_0 output 32, fwd_hit_1 output 1, fwd_data_1 output 32: bypass of the staged write.

Function
REQ-011 SHALL be a valid/ready handshake: a transfer occurs in a cycle where valid and ready are both high; ready SHALL depend combinationally on valid inputs and state only, never on data.
REQ-012 SHALL grant at most one requester per cycle; a non-granted requester holds valid, addr and data stable until accepted.
REQ-013 SHALL use FSM states NORMAL and FORCE1; in NORMAL req0 has priority; in FORCE1 req1 has priority.
REQ-014 SHALL keep a starve counter: +1 each cycle req1_valid is high and req1 loses; cleared when req1 is granted or req1_valid is low; saturates at STARVE_LIMIT.
REQ-015 SHALL move NORMAL->FORCE1 when the counter reaches STARVE_LIMIT, and FORCE1->NORMAL on the cycle req1 is granted.
REQ-016 SHALL register the accepted request: a transfer at edge N drives wb_en=1, wb_addr and wb_data during cycle N+1, so the write lands at edge N+1 (latency 1).
REQ-017 SHALL drive wb_en=0 in any cycle following no transfer; wb_addr and wb_data are don't-care then.
REQ-018 SHALL accept requests to address 0 but drive wb_en=0 for them, because $0 is hardwired zero.
REQ-019 SHALL assert fwd_hit_k combinationally when wb_en=1, wb_addr==rd_addr_k and rd_addr_k!=0; fwd_data_k SHALL then equal wb_data, else 0.
REQ-020 SHALL serialize same-address requests in grant order, so the last write wins in the register file.
REQ-021 SHALL never backpressure the winner: the output stage empties every cycle because the register file always accepts.

Reset
REQ-022 SHALL on rst_n low immediately force: wb_en=0, wb_addr=0, wb_data=0, FSM=NORMAL, starve counter=0.
REQ-023 SHALL hold req0_ready=req1_ready=0 and fwd_hit_0/1=0 while rst_n is low.
REQ-024 SHALL drop a request staged for write when reset asserts mid-operation; it is never written.
REQ-025 SHALL allow a grant in the first cycle after rst_n deasserts.

Structure
REQ-026 SHALL take the FSM state encoding and the register-index width (5) from shared package cpu_pkg.
REQ-027 SHALL hold the staged write in one sub-module, wb_stage_reg (address/data/enable register plus bypass compare); arbitration and FSM live in the top.

Verification
REQ-028 Reset: rst_n low mid-write with stage holding addr 5 -> wb_en=0 at once; register 5 unchanged.
REQ-029 Single request: req0 addr 3 data 0xDEADBEEF at edge N -> wb_en=1, wb_addr=3, wb_data=0xDEADBEEF in cycle N+1; fwd_hit_0=1 with rd_addr_0=3.
REQ-030 Contention: both valid continuously, STARVE_LIMIT=4 -> req0 granted 4 cycles, req1 granted in the 5th, then req0 again.
REQ-031 Zero register: req1 addr 0 data 0x1234 -> req1_ready=1, wb_en=0 next cycle; fwd_hit_0=0 with rd_addr_0=0.
REQ-032 Same address: req0 then req1 to addr 7 (0xA, then 0xB) -> register 7 reads 0xB after both writes.
